// File: rtl/io_controller.sv
// Responder for the processor's IN/OUT handshake: debounces the pushbutton, captures the
// switches for IN while holding the PC in halt, and latches register values to the display on OUT.
module io_controller #(
   parameter int         DATA_W          = 32,
   parameter int         DEBOUNCE_CYCLES = 4,
   parameter logic [5:0] OP_IN           = 6'b100000,
   parameter logic [5:0] OP_OUT          = 6'b100010
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              IO_UC,
   input  logic [5:0]        Modo_Funcao_UC,
   input  logic              botao,
   input  logic [DATA_W-1:0] chaves,
   input  logic [DATA_W-1:0] dado_saida,
   output logic [DATA_W-1:0] dado_entrada,
   output logic              entrada_pronta,
   output logic              halt,
   output logic [DATA_W-1:0] display,
   output logic              display_valido
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_WAIT_PRESS = 2'd1,
      S_DONE       = 2'd2
   } state_t;

   logic              r_btn_p0;
   logic              r_btn_p1;
   logic              r_deb;
   logic              r_deb_d;
   logic [CNT_W-1:0]  r_cnt;
   state_t            r_state;
   logic [DATA_W-1:0] r_dado_entrada;
   logic [DATA_W-1:0] r_display;
   logic              r_display_valido;

   logic w_press_evt;
   logic w_is_in;
   logic w_is_out;

   assign w_press_evt = r_deb & ~r_deb_d;
   assign w_is_in     = IO_UC & (Modo_Funcao_UC == OP_IN);
   assign w_is_out    = IO_UC & (Modo_Funcao_UC == OP_OUT);

   // Two-flop synchronizer, then a level must persist DEBOUNCE_CYCLES samples to be accepted
   always_ff @(posedge clock) begin
      if (reset) begin
         r_btn_p0 <= 1'b0;
         r_btn_p1 <= 1'b0;
         r_deb    <= 1'b0;
         r_deb_d  <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_btn_p0 <= botao;
         r_btn_p1 <= r_btn_p0;
         r_deb_d  <= r_deb;
         if (r_btn_p1 == r_deb) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_MAX) begin
            r_deb <= r_btn_p1;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state          <= S_IDLE;
         r_dado_entrada   <= '0;
         r_display        <= '0;
         r_display_valido <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_is_in) begin
                  r_state <= S_WAIT_PRESS;
               end else if (w_is_out) begin
                  r_display        <= dado_saida;
                  r_display_valido <= 1'b1;
               end
            end
            S_WAIT_PRESS: begin
               if (w_press_evt) begin
                  r_dado_entrada <= chaves;
                  r_state        <= S_DONE;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // halt must rise in the decode cycle itself, so it is partly combinational on the request
   assign halt = ~reset & ((r_state == S_WAIT_PRESS) | ((r_state == S_IDLE) & w_is_in));
   assign entrada_pronta = ~reset & (r_state == S_DONE);
   assign dado_entrada   = r_dado_entrada;
   assign display        = r_display;
   assign display_valido = r_display_valido;

endmodule

// File: tb/tb_io_controller.sv
// Directed bench for io_controller with DEBOUNCE_CYCLES=4 and hand-computed expectations.
module tb_io_controller;

   localparam int         DATA_W = 32;
   localparam logic [5:0] OP_IN  = 6'b100000;
   localparam logic [5:0] OP_OUT = 6'b100010;

   logic              clock = 1'b0;
   logic              reset;
   logic              IO_UC;
   logic [5:0]        Modo_Funcao_UC;
   logic              botao;
   logic [DATA_W-1:0] chaves;
   logic [DATA_W-1:0] dado_saida;
   logic [DATA_W-1:0] dado_entrada;
   logic              entrada_pronta;
   logic              halt;
   logic [DATA_W-1:0] display;
   logic              display_valido;

   int n_cmp = 0;
   int n_err = 0;

   io_controller #(
      .DATA_W(DATA_W), .DEBOUNCE_CYCLES(4), .OP_IN(OP_IN), .OP_OUT(OP_OUT)
   ) dut (
      .clock(clock), .reset(reset), .IO_UC(IO_UC), .Modo_Funcao_UC(Modo_Funcao_UC),
      .botao(botao), .chaves(chaves), .dado_saida(dado_saida),
      .dado_entrada(dado_entrada), .entrada_pronta(entrada_pronta), .halt(halt),
      .display(display), .display_valido(display_valido)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic watch(input int n, output int pr, output int hl);
      pr = 0;
      hl = 0;
      for (int i = 0; i < n; i++) begin
         cyc(1);
         if (entrada_pronta) pr++;
         if (halt) hl++;
      end
   endtask

   task automatic wait_pronta(input int limit, output int k, output logic [31:0] d);
      k = -1;
      d = '0;
      for (int i = 1; i <= limit; i++) begin
         cyc(1);
         if (entrada_pronta && k < 0) begin
            k = i;
            d = dado_entrada;
         end
      end
   endtask

   task automatic issue_in(input string tag);
      IO_UC          = 1'b1;
      Modo_Funcao_UC = OP_IN;
      #1;
      check(tag, 32'(halt), 32'd1);
      cyc(1);
      IO_UC = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          pr, hl, k;
      logic [31:0] d;
      logic        halt_at [1:10];
      logic        pr_at   [1:10];

      reset = 1'b1; IO_UC = 1'b1; Modo_Funcao_UC = OP_IN; botao = 1'b1;
      chaves = 32'h0; dado_saida = 32'h0;
      cyc(3);
      check("rst_halt", 32'(halt), 32'd0);
      check("rst_pronta", 32'(entrada_pronta), 32'd0);
      check("rst_dado", dado_entrada, 32'h0);
      check("rst_display", display, 32'h0);
      check("rst_valido", 32'(display_valido), 32'd0);

      // Button pulse with no IN pending must be ignored
      reset = 1'b0; IO_UC = 1'b0; botao = 1'b0;
      cyc(2);
      botao = 1'b1;
      watch(20, pr, hl);
      botao = 1'b0;
      begin
         int pr2, hl2;
         watch(10, pr2, hl2);
         pr += pr2; hl += hl2;
      end
      check("idle_pronta", 32'(pr), 32'd0);
      check("idle_halt", 32'(hl), 32'd0);

      // Clean IN: press at cycle t, DONE at t+7
      chaves = 32'h0000_00A5;
      issue_in("in_halt_decode");
      watch(3, pr, hl);
      check("in_halt_wait", 32'(hl), 32'd3);
      botao = 1'b1;
      k = -1; d = '0;
      for (int i = 1; i <= 10; i++) begin
         cyc(1);
         halt_at[i] = halt;
         pr_at[i]   = entrada_pronta;
         if (entrada_pronta && k < 0) begin
            k = i;
            d = dado_entrada;
         end
      end
      check("in_latency", 32'(k), 32'd7);
      check("in_data", d, 32'h0000_00A5);
      check("in_halt_t6", 32'(halt_at[6]), 32'd1);
      check("in_halt_t7", 32'(halt_at[7]), 32'd0);
      check("in_pronta_t8", 32'(pr_at[8]), 32'd0);
      botao = 1'b0;
      cyc(10);

      // Bounce rejection, then a stable press
      chaves = 32'h0000_005A;
      issue_in("bnc_halt_decode");
      pr = 0; hl = 0;
      for (int i = 0; i < 20; i++) begin
         botao = ((i % 4) < 2);
         cyc(1);
         if (entrada_pronta) pr++;
         if (!halt) hl++;
      end
      botao = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc(1);
         if (entrada_pronta) pr++;
         if (!halt) hl++;
      end
      check("bnc_pronta", 32'(pr), 32'd0);
      check("bnc_halt_low", 32'(hl), 32'd0);
      botao = 1'b1;
      wait_pronta(10, k, d);
      check("bnc_press_lat", 32'(k), 32'd7);
      check("bnc_data", d, 32'h0000_005A);
      botao = 1'b0;
      cyc(10);

      // OUT writes and overwrites the display
      IO_UC = 1'b1; Modo_Funcao_UC = OP_OUT; dado_saida = 32'hDEAD_BEEF;
      #1;
      check("out_halt", 32'(halt), 32'd0);
      cyc(1);
      check("out_display1", display, 32'hDEAD_BEEF);
      check("out_valido", 32'(display_valido), 32'd1);
      dado_saida = 32'h0000_0001;
      cyc(1);
      check("out_display2", display, 32'h0000_0001);
      check("out_halt2", 32'(halt), 32'd0);
      check("out_keep_dado", dado_entrada, 32'h0000_005A);
      IO_UC = 1'b0;
      cyc(2);

      // Back-to-back IN with button held: second needs release and fresh press
      chaves = 32'h0000_0011;
      issue_in("b2b_halt1");
      botao = 1'b1;
      wait_pronta(12, k, d);
      check("b2b_lat1", 32'(k), 32'd7);
      check("b2b_data1", d, 32'h0000_0011);
      chaves = 32'h0000_003C;
      issue_in("b2b_halt2");
      watch(15, pr, hl);
      check("b2b_held_pronta", 32'(pr), 32'd0);
      check("b2b_held_halt", 32'(hl), 32'd15);
      botao = 1'b0;
      watch(8, pr, hl);
      check("b2b_rel_pronta", 32'(pr), 32'd0);
      check("b2b_rel_halt", 32'(hl), 32'd8);
      botao = 1'b1;
      wait_pronta(12, k, d);
      check("b2b_lat2", 32'(k), 32'd7);
      check("b2b_data2", d, 32'h0000_003C);
      botao = 1'b0;
      cyc(10);

      // Reset while waiting for the press
      chaves = 32'h0000_0099;
      issue_in("rstw_halt_decode");
      cyc(2);
      check("rstw_halt_pre", 32'(halt), 32'd1);
      reset = 1'b1;
      #1;
      check("rstw_halt_same", 32'(halt), 32'd0);
      cyc(1);
      reset = 1'b0;
      #1;
      check("rstw_dado", dado_entrada, 32'h0);
      check("rstw_display", display, 32'h0);
      check("rstw_valido", 32'(display_valido), 32'd0);
      check("rstw_halt_post", 32'(halt), 32'd0);
      botao = 1'b1;
      watch(10, pr, hl);
      check("rstw_pronta", 32'(pr), 32'd0);
      check("rstw_halt_press", 32'(hl), 32'd0);
      check("rstw_nocapture", dado_entrada, 32'h0);
      botao = 1'b0;
      cyc(8);
      IO_UC = 1'b1; Modo_Funcao_UC = OP_OUT; dado_saida = 32'h0000_0055;
      cyc(1);
      IO_UC = 1'b0;
      check("rstw_idle_out", display, 32'h0000_0055);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/io_controller.md
Name: io_controller

Overview:
- Responder side of the processor's IN/OUT handshake. The control unit raises IO_UC with an IN or OUT opcode and stalls on halt.
- This block services those requests. IN: synchronizes and debounces the pushbutton, captures the switches on a press, then releases halt. OUT: latches the register value into the display register.
- Sits between the datapath (write-back mux input 11, PC stall) and the board switches, button and display.

Parameters:
- DATA_W, 32, width of switch input, captured data, output data and display.
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples needed to accept a button level change (≥2; board build uses 500000).
- OP_IN, 6'b100000, opcode of IN.
- OP_OUT, 6'b100010, opcode of OUT.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- IO_UC  input  1  control unit flags an I/O instruction this cycle.
- Modo_Funcao_UC  input  6  current opcode.
- botao  input  1  raw pushbutton, asynchronous, pressed = 1.
- chaves  input  DATA_W  switch values, assumed quasi-static.
- dado_saida  input  DATA_W  register-file value for OUT.
- dado_entrada  output  DATA_W  value captured for IN write-back.
- entrada_pronta  output  1  one-cycle pulse: dado_entrada valid, write-back allowed.
- halt  output  1  stall PC while an IN is pending.
- display  output  DATA_W  last OUT value.
- display_valido  output  1  high once any OUT has completed since reset.

Behaviour:
- Reset (synchronous, active-high):
  - sync flops, debounced level, debounce counter, dado_entrada, display and display_valido all clear to 0.
  - FSM goes to IDLE.
  - halt=0 and entrada_pronta=0 while reset is high, regardless of inputs.
- Synchronizer: two flops on botao.
- Debouncer:
  - If sync output equals the debounced level, counter clears to 0.
  - Otherwise counter increments. When it reaches DEBOUNCE_CYCLES-1 with the input still differing, the debounced level flips and the counter clears.
  - Counter width is ceil(log2(DEBOUNCE_CYCLES)); it never wraps.
- press_evt: single-cycle pulse on the 0→1 transition of the debounced level.
  - Latency from a clean raw rise to press_evt is 2+DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no event.
- Decode:
  - is_in = IO_UC & (Modo_Funcao_UC==OP_IN).
  - is_out = IO_UC & (Modo_Funcao_UC==OP_OUT).
  - Any other opcode with IO_UC=1 is ignored.
- FSM states: IDLE, WAIT_PRESS, DONE.
  - IDLE, is_in: halt=1 combinationally in the same cycle; next state WAIT_PRESS. A press_evt in this same cycle is discarded.
  - IDLE, is_out: display<=dado_saida and display_valido<=1 at the next edge; halt stays 0; state stays IDLE.
  - IDLE, neither: no action. A press_evt seen in IDLE is discarded, never queued.
  - WAIT_PRESS: halt=1. On press_evt: dado_entrada<=chaves, next state DONE. Otherwise stay, with no timeout.
  - DONE: halt=0 and entrada_pronta=1 for exactly this cycle; dado_entrada holds the captured value. Next state IDLE. is_in or is_out in this cycle is not acted on; the PC advances on this edge.
- Back-to-back IN: each needs its own new press. Holding the button produces one event only, because the debounced level must return to 0 before another rise.
- Outputs:
  - dado_entrada and display hold their values until overwritten.
  - display_valido stays 1 until reset.
- Reset asserted in WAIT_PRESS or DONE: halt drops in that cycle, no capture occurs, FSM returns to IDLE.

Test Plan:
- Reset then idle: outputs all 0; raw botao pulse of 20 cycles in IDLE → no entrada_pronta, halt stays 0.
- IN with clean press, DEBOUNCE_CYCLES=4, chaves=32'h0000_00A5: halt=1 from the decode cycle. botao rises at cycle t → press_evt at t+6, DONE at t+7 with entrada_pronta=1, dado_entrada=0xA5, halt=0 → IDLE at t+8.
- Bounce rejection during WAIT_PRESS: botao toggles 1/0 every 2 cycles for 20 cycles, then stays 0 → halt remains 1, no capture. A subsequent 10-cycle stable press captures normally.
- OUT with dado_saida=32'hDEAD_BEEF: next edge display=0xDEADBEEF, display_valido=1, halt never asserted. Following OUT of 0x1 overwrites display to 0x1.
- Two consecutive INs with the button held throughout: first IN completes. Second stays halted until the button is released for ≥6 cycles and pressed again, then captures the new chaves=0x3C.
- Reset asserted mid-WAIT_PRESS: same-cycle halt=0. After release FSM is IDLE, dado_entrada=0, a press without IN causes no capture.
